uart_axil_fifo_wrap: RTL

- AXI4-Lite slave register block that fronts a UART TX/RX core pair.
- Parametrised TX and RX FIFOs decouple the bus from the serial rate.
- A TX drain FSM feeds the TX core one byte at a time.
- Also provides a sticky RX-overrun flag, software FIFO flush, fill levels and a masked level-sensitive interrupt.
- Sits between the SoC interconnect and the uart tx/rx cores.

---
 rtl/uart_axil_fifo_wrap_if.sv | 32 +++
 rtl/uart_axil_fifo_wrap.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_axil_fifo_wrap_if.sv
// AXI4-Lite channel bundle between the SoC interconnect and the UART register block.
interface uart_axil_fifo_wrap_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic [ADDR_WIDTH-1:0] awaddr;
   logic                  awvalid;
   logic                  awready;
   logic [DATA_WIDTH-1:0] wdata;
   logic                  wvalid;
   logic                  wready;
   logic [1:0]            bresp;
   logic                  bvalid;
   logic                  bready;
   logic [ADDR_WIDTH-1:0] araddr;
   logic                  arvalid;
   logic                  arready;
   logic [DATA_WIDTH-1:0] rdata;
   logic [1:0]            rresp;
   logic                  rvalid;
   logic                  rready;

   modport master (
      output awaddr, awvalid, wdata, wvalid, bready, araddr, arvalid, rready,
      input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );

   modport slave (
      input  awaddr, awvalid, wdata, wvalid, bready, araddr, arvalid, rready,
      output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );
endinterface

// File: rtl/uart_axil_fifo_wrap.sv
// AXI4-Lite register block fronting a UART TX/RX core pair: TX/RX FIFOs,
// a one-byte-at-a-time TX drain FSM, sticky RX overrun, flush control,
// fill levels and a masked level-sensitive interrupt.
module uart_axil_fifo_wrap #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int TX_DEPTH   = 16,
   parameter int RX_DEPTH   = 16,
   parameter int BAUD_W     = 3
) (
   input  logic                clk,
   input  logic                rst,
   uart_axil_fifo_wrap_if.slave s_axil,
   output logic [7:0]          uart_tx_data,
   output logic                uart_tx_start,
   input  logic                uart_tx_busy,
   input  logic [7:0]          uart_rx_data,
   input  logic                uart_rx_valid,
   output logic [BAUD_W-1:0]   baud_sel,
   output logic                irq
);
   localparam int TX_AW = $clog2(TX_DEPTH);
   localparam int RX_AW = $clog2(RX_DEPTH);
   localparam int TX_CW = TX_AW + 1;
   localparam int RX_CW = RX_AW + 1;

   localparam logic [7:0] A_TXDATA = 8'h00;
   localparam logic [7:0] A_RXDATA = 8'h04;
   localparam logic [7:0] A_STATUS = 8'h08;
   localparam logic [7:0] A_BAUD   = 8'h0C;
   localparam logic [7:0] A_IRQEN  = 8'h10;
   localparam logic [7:0] A_CTRL   = 8'h14;
   localparam logic [7:0] A_LEVEL  = 8'h18;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {TX_IDLE, TX_LAUNCH, TX_SETTLE, TX_WAIT} tx_state_t;
   tx_state_t tx_state;

   logic                  bvalid_q;
   logic [1:0]            bresp_q;
   logic                  rvalid_q;
   logic [1:0]            rresp_q;
   logic [DATA_WIDTH-1:0] rdata_q;
   logic [BAUD_W-1:0]     baud_q;
   logic [2:0]            irq_en_q;
   logic                  rx_overrun_q;
   logic                  flush_tx_q;
   logic                  flush_rx_q;
   logic                  irq_q;

   logic [7:0]       tx_mem [TX_DEPTH];
   logic [TX_AW-1:0] tx_wr_ptr, tx_rd_ptr;
   logic [TX_CW-1:0] tx_count;
   logic [7:0]       rx_mem [RX_DEPTH];
   logic [RX_AW-1:0] rx_wr_ptr, rx_rd_ptr;
   logic [RX_CW-1:0] rx_count;

   logic tx_full, tx_empty, rx_full, rx_empty;
   logic [5:0] status;

   logic [7:0]            wr_addr, rd_addr;
   logic                  wr_hs, wr_err, wr_apply, tx_push, tx_pop;
   logic                  rd_hs, rd_err, rx_pop, rx_push, rx_drop;
   logic [DATA_WIDTH-1:0] rd_data_d;
   logic                  unused_bits;

   assign tx_full  = (tx_count == TX_CW'(TX_DEPTH));
   assign tx_empty = (tx_count == '0);
   assign rx_full  = (rx_count == RX_CW'(RX_DEPTH));
   assign rx_empty = (rx_count == '0);

   assign status = {rx_overrun_q, rx_full, tx_empty, tx_full, ~rx_empty,
                    (tx_state != TX_IDLE) | uart_tx_busy};

   assign wr_addr = s_axil.awaddr[7:0];
   assign rd_addr = s_axil.araddr[7:0];

   // A write is taken only when both address and data are offered and no response is pending
   assign wr_hs    = s_axil.awvalid & s_axil.wvalid & ~bvalid_q;
   assign wr_apply = wr_hs & ~wr_err;
   assign tx_push  = wr_apply & (wr_addr == A_TXDATA);

   // The drain FSM takes the head byte on its way out of IDLE; a pending flush blocks it
   assign tx_pop = (tx_state == TX_IDLE) & ~tx_empty & ~flush_tx_q;

   assign rd_hs   = s_axil.arvalid & ~rvalid_q;
   assign rx_pop  = rd_hs & (rd_addr == A_RXDATA) & ~rx_empty;
   assign rx_push = uart_rx_valid & (~rx_full | rx_pop);
   assign rx_drop = uart_rx_valid & rx_full & ~rx_pop & ~flush_rx_q;

   assign unused_bits = ^{s_axil.awaddr[ADDR_WIDTH-1:8], s_axil.araddr[ADDR_WIDTH-1:8],
                          s_axil.wdata[DATA_WIDTH-1:8]};

   assign s_axil.awready = wr_hs;
   assign s_axil.wready  = wr_hs;
   assign s_axil.bvalid  = bvalid_q;
   assign s_axil.bresp   = bresp_q;
   assign s_axil.arready = rd_hs;
   assign s_axil.rvalid  = rvalid_q;
   assign s_axil.rresp   = rresp_q;
   assign s_axil.rdata   = rdata_q;
   assign baud_sel       = baud_q;
   assign irq            = irq_q;

   // Write decode: unmapped, read-only and full-TX writes are rejected with no side effect
   always_comb begin
      wr_err = 1'b0;
      case (wr_addr)
         A_TXDATA:                          wr_err = tx_full;
         A_STATUS, A_BAUD, A_IRQEN, A_CTRL: wr_err = 1'b0;
         default:                           wr_err = 1'b1;
      endcase
   end

   // Read mux: the value captured into rdata on the address handshake
   always_comb begin
      rd_data_d = '0;
      rd_err    = 1'b0;
      case (rd_addr)
         A_TXDATA: rd_data_d = '0;
         A_RXDATA: begin
            if (rx_empty) rd_err = 1'b1;
            else          rd_data_d[7:0] = rx_mem[rx_rd_ptr];
         end
         A_STATUS: rd_data_d[5:0] = status;
         A_BAUD:   rd_data_d[BAUD_W-1:0] = baud_q;
         A_IRQEN:  rd_data_d[2:0] = irq_en_q;
         A_CTRL:   rd_data_d = '0;
         A_LEVEL: begin
            rd_data_d[15:8] = 8'(rx_count);
            rd_data_d[7:0]  = 8'(tx_count);
         end
         default:  rd_err = 1'b1;
      endcase
   end

   // Write response: raised the cycle after the handshake, held until the master accepts it
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bvalid_q <= 1'b0;
         bresp_q  <= RESP_OKAY;
      end else if (wr_hs) begin
         bvalid_q <= 1'b1;
         bresp_q  <= wr_err ? RESP_SLVERR : RESP_OKAY;
      end else if (s_axil.bready) begin
         bvalid_q <= 1'b0;
      end
   end

   // Read response: data and status frozen from the handshake until rready
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rvalid_q <= 1'b0;
         rresp_q  <= RESP_OKAY;
         rdata_q  <= '0;
      end else if (rd_hs) begin
         rvalid_q <= 1'b1;
         rresp_q  <= rd_err ? RESP_SLVERR : RESP_OKAY;
         rdata_q  <= rd_data_d;
      end else if (s_axil.rready) begin
         rvalid_q <= 1'b0;
      end
   end

   // Control registers, one-cycle flush pulses and the sticky overrun flag (new overrun beats clear)
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         baud_q       <= '0;
         irq_en_q     <= '0;
         flush_tx_q   <= 1'b0;
         flush_rx_q   <= 1'b0;
         rx_overrun_q <= 1'b0;
      end else begin
         flush_tx_q <= wr_apply & (wr_addr == A_CTRL) & s_axil.wdata[0];
         flush_rx_q <= wr_apply & (wr_addr == A_CTRL) & s_axil.wdata[1];
         if (wr_apply && wr_addr == A_BAUD)  baud_q   <= s_axil.wdata[BAUD_W-1:0];
         if (wr_apply && wr_addr == A_IRQEN) irq_en_q <= s_axil.wdata[2:0];
         if (rx_drop)
            rx_overrun_q <= 1'b1;
         else if (wr_apply && wr_addr == A_STATUS && s_axil.wdata[5])
            rx_overrun_q <= 1'b0;
      end
   end

   // TX FIFO: bus pushes, drain FSM pops, flush wins over both
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_wr_ptr <= '0;
         tx_rd_ptr <= '0;
         tx_count  <= '0;
         for (int i = 0; i < TX_DEPTH; i++) tx_mem[i] <= '0;
      end else if (flush_tx_q) begin
         tx_wr_ptr <= '0;
         tx_rd_ptr <= '0;
         tx_count  <= '0;
      end else begin
         if (tx_push) begin
            tx_mem[tx_wr_ptr] <= s_axil.wdata[7:0];
            tx_wr_ptr         <= tx_wr_ptr + TX_AW'(1);
         end
         if (tx_pop) tx_rd_ptr <= tx_rd_ptr + TX_AW'(1);
         case ({tx_push, tx_pop})
            2'b10:   tx_count <= tx_count + TX_CW'(1);
            2'b01:   tx_count <= tx_count - TX_CW'(1);
            default: tx_count <= tx_count;
         endcase
      end
   end

   // RX FIFO: a full FIFO still accepts a byte when a read pops on the same cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_wr_ptr <= '0;
         rx_rd_ptr <= '0;
         rx_count  <= '0;
         for (int i = 0; i < RX_DEPTH; i++) rx_mem[i] <= '0;
      end else if (flush_rx_q) begin
         rx_wr_ptr <= '0;
         rx_rd_ptr <= '0;
         rx_count  <= '0;
      end else begin
         if (rx_push) begin
            rx_mem[rx_wr_ptr] <= uart_rx_data;
            rx_wr_ptr         <= rx_wr_ptr + RX_AW'(1);
         end
         if (rx_pop) rx_rd_ptr <= rx_rd_ptr + RX_AW'(1);
         case ({rx_push, rx_pop})
            2'b10:   rx_count <= rx_count + RX_CW'(1);
            2'b01:   rx_count <= rx_count - RX_CW'(1);
            default: rx_count <= rx_count;
         endcase
      end
   end

   // TX drain FSM: start is high only in LAUNCH, data holds until the next launch, busy ignored in SETTLE
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_state      <= TX_IDLE;
         uart_tx_data  <= '0;
         uart_tx_start <= 1'b0;
      end else begin
         uart_tx_start <= 1'b0;
         case (tx_state)
            TX_IDLE: begin
               if (tx_pop) begin
                  uart_tx_data  <= tx_mem[tx_rd_ptr];
                  uart_tx_start <= 1'b1;
                  tx_state      <= TX_LAUNCH;
               end
            end
            TX_LAUNCH: tx_state <= TX_SETTLE;
            TX_SETTLE: tx_state <= TX_WAIT;
            TX_WAIT:   if (!uart_tx_busy) tx_state <= TX_IDLE;
            default:   tx_state <= TX_IDLE;
         endcase
      end
   end

   // Interrupt: level of the enabled sources, registered once
   always_ff @(posedge clk or posedge rst) begin
      if (rst) irq_q <= 1'b0;
      else     irq_q <= |(irq_en_q & {rx_overrun_q, tx_empty, ~rx_empty});
   end
endmodule
